// File: rtl/gate_chk_pkg.sv
// Shared types and constants for the gate vector checker and its golden model.
package gate_chk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam int GATE_W  = 7;
  localparam int AND_B   = 6;
  localparam int OR_B    = 5;
  localparam int NAND_B  = 4;
  localparam int NOR_B   = 3;
  localparam int XOR_B   = 2;
  localparam int XNOR_B  = 1;
  localparam int NOT_B   = 0;
  localparam int NUM_VEC = 4;

  function automatic logic [2:0] popcount7(input logic [GATE_W-1:0] v);
    logic [2:0] cnt;
    cnt = 3'd0;
    for (int i = 0; i < GATE_W; i++) begin
      cnt = cnt + {2'b00, v[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/gate_golden.sv
// Combinational reference for the basic-gates block, in gate_out bit order.
module gate_golden
  import gate_chk_pkg::*;
(
  input  logic              a,
  input  logic              b,
  output logic [GATE_W-1:0] expected
);

  // Golden gate values for one input pair
  always_comb begin
    expected         = '0;
    expected[AND_B]  = a & b;
    expected[OR_B]   = a | b;
    expected[NAND_B] = ~(a & b);
    expected[NOR_B]  = ~(a | b);
    expected[XOR_B]  = a ^ b;
    expected[XNOR_B] = ~(a ^ b);
    expected[NOT_B]  = ~a;
  end

endmodule

// File: rtl/gate_vector_checker.sv
// Sweeps a/b over all four vectors, samples gate_out after a settle delay and
// accumulates mismatched bits against the golden model.
module gate_vector_checker
  import gate_chk_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1,
  parameter int ERR_W         = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              a,
  output logic              b,
  input  logic [GATE_W-1:0] gate_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_count,
  output logic [1:0]        first_fail_vec,
  output logic              fail_valid
);

  localparam logic [3:0]       SETTLE_LD = 4'(SETTLE_CYCLES);
  localparam logic [ERR_W-1:0] ERR_MAX   = '1;
  localparam logic [1:0]       LAST_VEC  = 2'(NUM_VEC - 1);

  state_t            state;
  state_t            next_state;
  logic [1:0]        vec;
  logic [3:0]        settle_cnt;
  logic [GATE_W-1:0] golden;
  logic [GATE_W-1:0] mismatch;
  logic [ERR_W:0]    err_sum;
  logic [ERR_W-1:0]  err_next;

  gate_golden u_golden (
    .a        (vec[1]),
    .b        (vec[0]),
    .expected (golden)
  );

  // Mismatch popcount and saturating accumulation
  always_comb begin
    mismatch = gate_out ^ golden;
    err_sum  = {1'b0, err_count} + {{(ERR_W-2){1'b0}}, popcount7(mismatch)};
    if (err_sum > {1'b0, ERR_MAX}) begin
      err_next = ERR_MAX;
    end else begin
      err_next = err_sum[ERR_W-1:0];
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (start) next_state = ST_SETTLE;
        else       next_state = ST_IDLE;
      end
      ST_SETTLE: begin
        if (settle_cnt <= 4'd1) next_state = ST_CHECK;
        else                    next_state = ST_SETTLE;
      end
      ST_CHECK: begin
        if (vec == LAST_VEC) next_state = ST_DONE;
        else                 next_state = ST_SETTLE;
      end
      ST_DONE: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  // Sweep datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec            <= 2'd0;
      settle_cnt     <= 4'd0;
      a              <= 1'b0;
      b              <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      first_fail_vec <= 2'd0;
      fail_valid     <= 1'b0;
    end else begin
      busy <= (next_state == ST_SETTLE) || (next_state == ST_CHECK);
      done <= (next_state == ST_DONE);
      case (state)
        ST_IDLE: begin
          if (start) begin
            vec        <= 2'd0;
            {a, b}     <= 2'b00;
            settle_cnt <= SETTLE_LD;
            err_count  <= '0;
            fail_valid <= 1'b0;
            pass       <= 1'b0;
          end
        end
        ST_SETTLE: settle_cnt <= settle_cnt - 4'd1;
        ST_CHECK: begin
          err_count <= err_next;
          if ((mismatch != '0) && !fail_valid) begin
            first_fail_vec <= vec;
            fail_valid     <= 1'b1;
          end
          // The last vector drops a/b back to 00 so 11 is held no longer than the others
          if (vec == LAST_VEC) begin
            {a, b} <= 2'b00;
          end else begin
            vec        <= vec + 2'd1;
            {a, b}     <= vec + 2'd1;
            settle_cnt <= SETTLE_LD;
          end
        end
        ST_DONE: pass <= (err_count == '0);
        default: vec <= 2'd0;
      endcase
    end
  end

endmodule

// File: doc/gate_vector_checker.md
# gate_vector_checker

Self-checking hardware exerciser for the two-input basic-gates block. It drives the exhaustive input sweep (a,b = 00, 01, 10, 11) into the gates block and samples its seven outputs after a programmable settle time. Each sample is compared against a built-in golden model, and the block reports the mismatch count, the first failing vector and a pass flag. The block sits beside the gates block as on-chip BIST or as a synthesizable bench driver.

## Interface
- SETTLE_CYCLES, 1: cycles `a`/`b` are held before outputs are sampled; legal range 1..15.
- ERR_W, 5: width of the error counter, which saturates.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  level sampled in IDLE only; launches one sweep.
- a  out  1  gate input A, registered.
- b  out  1  gate input B, registered.
- gate_out  in  7  gate outputs {and, or, nand, nor, xor, xnor, not}; bit 6 = and, bit 0 = not.
- busy  out  1  high from the first SETTLE cycle through the last CHECK cycle.
- done  out  1  single-cycle pulse at sweep end.
- pass  out  1  1 when the last sweep had zero mismatches.
- err_count  out  ERR_W  mismatched output bits summed over the sweep.
- first_fail_vec  out  2  {a,b} of the first vector with any mismatch.
- fail_valid  out  1  first_fail_vec is meaningful.

## Operation
- Golden model:
  - and = a&b, or = a|b, nand = ~(a&b), nor = ~(a|b).
  - xor = a^b, xnor = ~(a^b), not = ~a.
- FSM states: IDLE, SETTLE, CHECK, DONE.
- IDLE:
  - on start=1, load vec=0, drive {a,b}=00, load settle_cnt=SETTLE_CYCLES.
  - clear err_count, fail_valid and pass.
  - go to SETTLE.
- SETTLE: decrement settle_cnt each cycle; move to CHECK on the cycle the count reaches 1.
- CHECK:
  - mismatch = gate_out ^ golden(vec); err_count += popcount(mismatch), saturating at 2^ERR_W-1.
  - if mismatch≠0 and fail_valid=0, latch first_fail_vec=vec and set fail_valid=1.
  - if vec=3, go to DONE; otherwise vec+1, drive the new {a,b}, reload settle_cnt and go to SETTLE.
- DONE:
  - done=1 for one cycle; pass = (err_count==0) is computed here.
  - return to IDLE; {a,b} returns to 00.
- start outside IDLE is ignored. start held high re-launches a sweep on the cycle after DONE.
- pass, err_count, first_fail_vec and fail_valid hold their values until the next launch.
- Reset (rst_n=0, at any time, including mid-sweep): state returns to IDLE and every output is forced to its reset value immediately. No partial result is retained.

## Timing
- Reset values: a=0, b=0, busy=0, done=0, pass=0, err_count=0, first_fail_vec=00, fail_valid=0.
- All outputs are registered, and a/b change only on clock edges.
- The edge that samples start is cycle 0.
  - SETTLE for vector v spans cycles v·(S+1)+1 .. v·(S+1)+S, where S = SETTLE_CYCLES.
  - CHECK for vector v is at cycle (v+1)·(S+1).
  - done asserts at cycle 4·(S+1)+1; with S=1 this is cycle 9.
- gate_out is sampled in CHECK. The connected gates logic must settle within S cycles of the a/b change.
- Saturation: once err_count reaches its maximum it stays there, and pass is still 0.

## Structure
- Package gate_chk_pkg holds:
  - the state enum;
  - localparams for gate_out bit indices (AND_B=6 … NOT_B=0);
  - the NUM_VEC=4 constant.
- Sub-module gate_golden: purely combinational, takes a and b, outputs the 7-bit expected vector in the gate_out ordering. It is reused by benches.
- The top level contains the FSM, the vec/settle counters, the popcount and the saturating accumulator.

## Test plan
- Correct gates block attached, S=1, start pulse -> done at cycle 9, pass=1, err_count=0, fail_valid=0; a/b sequence 00,01,10,11 with 2 cycles each.
- and bit stuck at 0 -> mismatch only at vector 11; err_count=1, first_fail_vec=11, fail_valid=1, pass=0.
- not bit inverted -> 4 mismatches; err_count=4, first_fail_vec=00.
- gate_out stuck at 0000000 with ERR_W=3 -> 14 raw mismatches saturate to err_count=7, first_fail_vec=00, pass=0.
- start pulsed again while busy -> ignored, done timing unchanged. A second sweep after done with a correct DUT clears the previous failure: pass=1, err_count=0.
- rst_n low during SETTLE of vector 2 -> outputs return to their reset values at once, a=b=0. After release, a fresh start completes normally with done at cycle 9.
